// File: rtl/led_arb_pkg.sv
// Shared state encoding and default timing constants for the LED bank arbiter.
package led_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam int DEF_HOLD_CYC = 1000;
  localparam int DEF_PWM_BITS = 4;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first active request after i_last, wrapping.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IW-1:0]    i_last,
  output logic [N_REQ-1:0] o_win,
  output logic [IW-1:0]    o_idx,
  output logic             o_any
);

  logic [IW-1:0] w_c;

  // Scan farthest-first so the nearest candidate after i_last overwrites the rest.
  always_comb begin
    o_win = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_c   = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      w_c = IW'((int'(i_last) + k) % N_REQ);
      if (i_req[w_c]) begin
        o_win      = '0;
        o_win[w_c] = 1'b1;
        o_idx      = w_c;
        o_any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/led_arbiter.sv
// Round-robin owner of an 8-bit LED bank with minimum hold time, one-cycle gap
// between owners, and per-owner PWM brightness.
module led_arbiter
  import led_arb_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int HOLD_CYC = DEF_HOLD_CYC,
  parameter int PWM_BITS = DEF_PWM_BITS
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req,
  input  logic [8*N_REQ-1:0]        req_pattern,
  input  logic [PWM_BITS*N_REQ-1:0] req_duty,
  output logic [N_REQ-1:0]          grant,
  output logic [7:0]                led,
  output logic                      busy
);

  localparam int IW = $clog2(N_REQ);
  localparam int HW = $clog2(HOLD_CYC + 1);

  state_t              r_state;
  logic [N_REQ-1:0]    r_grant;
  logic [7:0]          r_led;
  logic                r_busy;
  logic [HW-1:0]       r_hold;
  logic [PWM_BITS-1:0] r_pwm;
  logic [IW-1:0]       r_last;

  logic [N_REQ-1:0]    w_win;
  logic [IW-1:0]       w_idx;
  logic                w_any;
  logic [IW-1:0]       w_sel_idx;
  logic [7:0]          w_sel_pat;
  logic [PWM_BITS-1:0] w_sel_duty;
  logic [PWM_BITS-1:0] w_pwm_nxt;
  logic                w_on;
  logic [7:0]          w_led_nxt;
  logic [HW-1:0]       w_hold_nxt;
  logic                w_own_req;
  logic                w_others;
  logic                w_release;

  rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
    .i_req  (req),
    .i_last (r_last),
    .o_win  (w_win),
    .o_idx  (w_idx),
    .o_any  (w_any)
  );

  // While owning, the owner's slice is re-latched every cycle; otherwise the
  // fresh winner's slice is latched on entry so led is valid with grant.
  assign w_sel_idx  = (r_state == ST_OWN) ? r_last : w_idx;
  assign w_sel_pat  = req_pattern[int'(w_sel_idx)*8 +: 8];
  assign w_sel_duty = req_duty[int'(w_sel_idx)*PWM_BITS +: PWM_BITS];

  // Compare against the counter value that will be current while led is shown.
  assign w_pwm_nxt  = r_pwm + PWM_BITS'(1);
  assign w_on       = (w_sel_duty == '1) || (w_sel_duty > w_pwm_nxt);
  assign w_led_nxt  = w_on ? w_sel_pat : 8'h00;

  assign w_hold_nxt = (r_hold == HW'(HOLD_CYC)) ? r_hold : r_hold + HW'(1);
  assign w_own_req  = |(req & r_grant);
  assign w_others   = |(req & ~r_grant);
  assign w_release  = !w_own_req || ((w_hold_nxt == HW'(HOLD_CYC)) && w_others);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_led   <= '0;
      r_busy  <= 1'b0;
      r_hold  <= '0;
      r_pwm   <= '0;
      r_last  <= IW'(N_REQ - 1);
    end else begin
      r_pwm <= w_pwm_nxt;
      case (r_state)
        ST_IDLE, ST_GAP: begin
          r_hold <= '0;
          if (w_any) begin
            r_state <= ST_OWN;
            r_grant <= w_win;
            r_last  <= w_idx;
            r_led   <= w_led_nxt;
            r_busy  <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_led   <= '0;
            r_busy  <= 1'b0;
          end
        end
        ST_OWN: begin
          if (w_release) begin
            r_state <= ST_GAP;
            r_grant <= '0;
            r_led   <= '0;
            r_busy  <= 1'b0;
            r_hold  <= '0;
          end else begin
            r_hold <= w_hold_nxt;
            r_led  <= w_led_nxt;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_grant <= '0;
          r_led   <= '0;
          r_busy  <= 1'b0;
          r_hold  <= '0;
        end
      endcase
    end
  end

  assign grant = r_grant;
  assign led   = r_led;
  assign busy  = r_busy;

endmodule

// File: tb/tb_led_arbiter.sv
// Directed bench for led_arbiter: N_REQ=4, HOLD_CYC=8, PWM_BITS=4.
module tb_led_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] pat;
  logic [15:0] duty;
  logic [3:0]  grant;
  logic [7:0]  led;
  logic        busy;

  int vectors;
  int miscompares;
  int edges;

  led_arbiter #(.N_REQ(4), .HOLD_CYC(8), .PWM_BITS(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_pattern (pat),
    .req_duty    (duty),
    .grant       (grant),
    .led         (led),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and sample 1ns after it; edges mirrors pwm_cnt since release.
  task automatic tick();
    @(posedge clk);
    #1;
    edges++;
  endtask

  task automatic chk_out(input string tag, input logic [3:0] g, input logic [7:0] l, input logic b);
    chk({tag, ".grant"}, 32'(grant), 32'(g));
    chk({tag, ".led"},   32'(led),   32'(l));
    chk({tag, ".busy"},  32'(busy),  32'(b));
  endtask

  initial begin
    int pw;
    logic [7:0] exp_led;
    vectors = 0; miscompares = 0; edges = 0;
    rst = 1'b1; req = '0; pat = '0; duty = '0;

    // Reset state
    #12;
    chk_out("reset", 4'b0000, 8'h00, 1'b0);

    // Single requester, full duty
    req = 4'b0001; pat[7:0] = 8'hA5; duty[3:0] = 4'hF;
    tick();
    chk_out("in_reset_held", 4'b0000, 8'h00, 1'b0);
    rst = 1'b0; edges = 0;
    tick();
    chk_out("single_first", 4'b0001, 8'hA5, 1'b1);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("single_led", 32'(led), 32'h0000_00A5);
    end
    chk("single_grant_hold", 32'(grant), 32'b0001);

    // PWM duty 4: on while pwm_cnt is 0..3
    pat[7:0] = 8'hFF; duty[3:0] = 4'h4;
    for (int i = 0; i < 32; i++) begin
      tick();
      pw = edges % 16;
      exp_led = (pw < 4) ? 8'hFF : 8'h00;
      chk("pwm4_led", 32'(led), 32'(exp_led));
    end

    // Duty 0: always off while still owning
    duty[3:0] = 4'h0;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("pwm0_led", 32'(led), 32'h0);
    end
    chk("pwm0_busy", 32'(busy), 32'h1);

    // Release -> GAP -> IDLE
    req = 4'b0000;
    tick();
    chk_out("release_gap", 4'b0000, 8'h00, 1'b0);
    tick();
    chk_out("idle", 4'b0000, 8'h00, 1'b0);

    // Preemption from reset with req=0011
    rst = 1'b1;
    #2;
    req = 4'b0011;
    pat[7:0] = 8'hA5; duty[3:0] = 4'hF;
    pat[15:8] = 8'h3C; duty[7:4] = 4'hF;
    pat[23:16] = 8'h0F; duty[11:8] = 4'hF;
    pat[31:24] = 8'hC3; duty[15:12] = 4'hF;
    tick();
    rst = 1'b0; edges = 0;
    tick();
    chk_out("pre_own0", 4'b0001, 8'hA5, 1'b1);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("pre_own0_hold", 32'(grant), 32'b0001);
    end
    tick();
    chk_out("pre_gap1", 4'b0000, 8'h00, 1'b0);
    tick();
    chk_out("pre_own1", 4'b0010, 8'h3C, 1'b1);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("pre_own1_hold", 32'(grant), 32'b0010);
    end
    tick();
    chk_out("pre_gap2", 4'b0000, 8'h00, 1'b0);
    tick();
    chk_out("pre_back0", 4'b0001, 8'hA5, 1'b1);

    // Early release in OWN cycle 3 with req2 pending
    req = 4'b0101;
    tick();
    chk("early_c2", 32'(grant), 32'b0001);
    tick();
    chk("early_c3", 32'(grant), 32'b0001);
    req = 4'b0100;
    tick();
    chk_out("early_gap", 4'b0000, 8'h00, 1'b0);
    tick();
    chk_out("early_own2", 4'b0100, 8'h0F, 1'b1);

    // Hold restarted: owner2 keeps 8 cycles; drop coincides with hold expiry
    req = 4'b1100;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("restart_hold", 32'(grant), 32'b0100);
    end
    req = 4'b1000;
    tick();
    chk_out("simul_gap", 4'b0000, 8'h00, 1'b0);
    tick();
    chk_out("simul_own3", 4'b1000, 8'hC3, 1'b1);
    tick();
    chk("simul_own3_stay", 32'(grant), 32'b1000);

    // Asynchronous reset mid-OWN
    rst = 1'b1;
    #2;
    chk_out("async_rst", 4'b0000, 8'h00, 1'b0);
    req = 4'b0100;
    tick();
    chk_out("rst_held", 4'b0000, 8'h00, 1'b0);
    rst = 1'b0; edges = 0;
    tick();
    chk_out("post_rst_own2", 4'b0100, 8'h0F, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
